req_latch8: RTL and testbench

REQ_LATCH8 -- requirements
Module: req_latch8

---
 rtl/req_latch8.sv | 85 ++++++++
 tb/tb_req_latch8.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/req_latch8.sv
`default_nettype none
// ============================================================================
// Module      : req_latch8
// Description : Eight-channel request latch. Synchronizes raw request lines,
//               captures edge or level events into a pending vector with
//               per-channel acknowledge, global clear and sticky overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module req_latch8 #(
    parameter int EDGE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req_in,
    input  logic       ack,
    input  logic [2:0] ack_idx,
    input  logic       clr_all,
    output logic [7:0] pend,
    output logic       any,
    output logic [7:0] ovf
);

    localparam int c_NCH = 8;

    logic [c_NCH-1:0] r_s1;
    logic [c_NCH-1:0] r_s2;
    logic [c_NCH-1:0] r_prev;
    logic [c_NCH-1:0] r_pend;
    logic [c_NCH-1:0] r_ovf;

    logic [c_NCH-1:0] w_evt;
    logic [c_NCH-1:0] w_set;
    logic [c_NCH-1:0] w_clear;
    logic [c_NCH-1:0] w_ovf_set;
    logic [c_NCH-1:0] w_pend_nxt;
    logic [c_NCH-1:0] w_ovf_nxt;

    // prev tracks s2 unconditionally so that en rising on an already-high
    // line does not look like a fresh edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_prev <= '0;
        end else begin
            r_s1   <= req_in;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    if (EDGE != 0) begin : g_edge
        assign w_evt     = r_s2 & ~r_prev;
        assign w_ovf_set = w_set & r_pend & ~w_clear;
    end else begin : g_level
        assign w_evt     = r_s2;
        assign w_ovf_set = '0;
    end

    for (genvar i = 0; i < c_NCH; i++) begin : g_ch
        assign w_clear[i] = (ack && (ack_idx == 3'(i))) || clr_all;
    end

    assign w_set      = w_evt & {c_NCH{en}};
    // A coincident set overrides the clear so no event is ever lost.
    assign w_pend_nxt = (r_pend & ~w_clear) | w_set;
    assign w_ovf_nxt  = clr_all ? '0 : (r_ovf | w_ovf_set);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= '0;
            r_ovf  <= '0;
        end else begin
            r_pend <= w_pend_nxt;
            r_ovf  <= w_ovf_nxt;
        end
    end

    assign pend = r_pend;
    assign ovf  = r_ovf;
    assign any  = |r_pend;

endmodule
`default_nettype wire

// File: tb/tb_req_latch8.sv
`default_nettype none
// ============================================================================
// Module      : tb_req_latch8
// Description : Directed self-checking bench for req_latch8 (edge and level).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_req_latch8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] req_in = 8'h00;
    logic       ack = 1'b0;
    logic [2:0] ack_idx = 3'd0;
    logic       clr_all = 1'b0;
    logic [7:0] pend;
    logic       any;
    logic [7:0] ovf;
    logic [7:0] pend_l;
    logic       any_l;
    logic [7:0] ovf_l;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    req_latch8 #(.EDGE(1)) dut (
        .clk(clk), .rst(rst), .en(en), .req_in(req_in), .ack(ack),
        .ack_idx(ack_idx), .clr_all(clr_all), .pend(pend), .any(any), .ovf(ovf)
    );

    req_latch8 #(.EDGE(0)) dut_lvl (
        .clk(clk), .rst(rst), .en(en), .req_in(req_in), .ack(ack),
        .ack_idx(ack_idx), .clr_all(clr_all), .pend(pend_l), .any(any_l), .ovf(ovf_l)
    );

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input logic [7:0] rin);
        rst = 1'b1; en = 1'b1; req_in = rin; ack = 1'b0; ack_idx = 3'd0; clr_all = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b1; req_in = 8'hFF; ack = 1'b1; ack_idx = 3'd5; clr_all = 1'b1;
        tick(3);
        total++; if (pend !== 8'h00) begin bad++; $display("FAIL reset_pend got=%h exp=00", pend); end
        total++; if (ovf !== 8'h00) begin bad++; $display("FAIL reset_ovf got=%h exp=00", ovf); end
        total++; if (any !== 1'b0) begin bad++; $display("FAIL reset_any got=%b exp=0", any); end
    endtask

    task automatic test_capture;
        do_reset(8'h00);
        req_in = 8'h04;
        tick(2);
        total++; if (pend !== 8'h00) begin bad++; $display("FAIL cap_latency got=%h exp=00", pend); end
        tick(1);
        total++; if (pend !== 8'h04) begin bad++; $display("FAIL cap_pend got=%h exp=04", pend); end
        total++; if (any !== 1'b1) begin bad++; $display("FAIL cap_any got=%b exp=1", any); end
        tick(5);
        total++; if (pend !== 8'h04) begin bad++; $display("FAIL cap_hold got=%h exp=04", pend); end
        total++; if (ovf !== 8'h00) begin bad++; $display("FAIL cap_norepeat_ovf got=%h exp=00", ovf); end
    endtask

    task automatic test_ack;
        ack = 1'b1; ack_idx = 3'd3;
        tick(1);
        ack = 1'b0;
        total++; if (pend !== 8'h04) begin bad++; $display("FAIL ack_wrong_idx got=%h exp=04", pend); end
        ack = 1'b1; ack_idx = 3'd2;
        tick(1);
        ack = 1'b0;
        total++; if (pend !== 8'h00) begin bad++; $display("FAIL ack_clear got=%h exp=00", pend); end
        total++; if (any !== 1'b0) begin bad++; $display("FAIL ack_any got=%b exp=0", any); end
        tick(4);
        total++; if (pend !== 8'h00) begin bad++; $display("FAIL ack_no_recapture got=%h exp=00", pend); end
        ack = 1'b1; ack_idx = 3'd2;
        tick(1);
        ack = 1'b0;
        total++; if (pend !== 8'h00) begin bad++; $display("FAIL ack_nonpending got=%h exp=00", pend); end
    endtask

    task automatic test_ovf;
        do_reset(8'h00);
        req_in = 8'h20;
        tick(3);
        total++; if (pend !== 8'h20) begin bad++; $display("FAIL ovf_setup got=%h exp=20", pend); end
        req_in = 8'h00;
        tick(3);
        req_in = 8'h20;
        tick(2);
        ack = 1'b1; ack_idx = 3'd5;
        tick(1);
        ack = 1'b0;
        total++; if (pend !== 8'h20) begin bad++; $display("FAIL ovf_setwins_pend got=%h exp=20", pend); end
        total++; if (ovf !== 8'h00) begin bad++; $display("FAIL ovf_acked got=%h exp=00", ovf); end
        req_in = 8'h00;
        tick(3);
        req_in = 8'h20;
        tick(3);
        total++; if (ovf !== 8'h20) begin bad++; $display("FAIL ovf_set got=%h exp=20", ovf); end
        total++; if (pend !== 8'h20) begin bad++; $display("FAIL ovf_pend got=%h exp=20", pend); end
    endtask

    task automatic test_enable;
        do_reset(8'h00);
        en = 1'b0;
        req_in = 8'h80;
        tick(4);
        req_in = 8'h00;
        tick(3);
        total++; if (pend !== 8'h00) begin bad++; $display("FAIL en_discard got=%h exp=00", pend); end
        req_in = 8'h80;
        tick(4);
        en = 1'b1;
        tick(4);
        total++; if (pend !== 8'h00) begin bad++; $display("FAIL en_late_nocap got=%h exp=00", pend); end
        req_in = 8'h00;
        tick(3);
        req_in = 8'h80;
        tick(3);
        total++; if (pend !== 8'h80) begin bad++; $display("FAIL en_recapture got=%h exp=80", pend); end
    endtask

    task automatic test_clr_all;
        do_reset(8'h00);
        req_in = 8'h81;
        tick(3);
        req_in = 8'h80;
        tick(3);
        req_in = 8'h81;
        tick(3);
        total++; if (pend !== 8'h81) begin bad++; $display("FAIL clr_setup_pend got=%h exp=81", pend); end
        total++; if (ovf !== 8'h01) begin bad++; $display("FAIL clr_setup_ovf got=%h exp=01", ovf); end
        clr_all = 1'b1; ack = 1'b1; ack_idx = 3'd4;
        tick(1);
        clr_all = 1'b0; ack = 1'b0;
        total++; if (pend !== 8'h00) begin bad++; $display("FAIL clr_pend got=%h exp=00", pend); end
        total++; if (ovf !== 8'h00) begin bad++; $display("FAIL clr_ovf got=%h exp=00", ovf); end
        // Rebuild pend[0], then fire ch0 (would overflow) and ch3 with clr_all.
        req_in = 8'h80;
        tick(3);
        req_in = 8'h81;
        tick(3);
        req_in = 8'h80;
        tick(3);
        total++; if (pend !== 8'h01) begin bad++; $display("FAIL clr_rebuild got=%h exp=01", pend); end
        req_in = 8'h89;
        tick(2);
        clr_all = 1'b1;
        tick(1);
        clr_all = 1'b0;
        total++; if (pend !== 8'h09) begin bad++; $display("FAIL clr_setwins got=%h exp=09", pend); end
        total++; if (ovf !== 8'h00) begin bad++; $display("FAIL clr_ovf_race got=%h exp=00", ovf); end
    endtask

    task automatic test_multi_level;
        do_reset(8'h00);
        req_in = 8'hA5;
        tick(3);
        total++; if (pend !== 8'hA5) begin bad++; $display("FAIL multi_pend got=%h exp=a5", pend); end
        total++; if (pend_l !== 8'hA5) begin bad++; $display("FAIL lvl_pend got=%h exp=a5", pend_l); end
        tick(3);
        total++; if (ovf_l !== 8'h00) begin bad++; $display("FAIL lvl_ovf got=%h exp=00", ovf_l); end
        ack = 1'b1; ack_idx = 3'd2;
        tick(1);
        ack = 1'b0;
        total++; if (pend !== 8'hA1) begin bad++; $display("FAIL multi_ack got=%h exp=a1", pend); end
        total++; if (pend_l !== 8'hA5) begin bad++; $display("FAIL lvl_reset_after_ack got=%h exp=a5", pend_l); end
        total++; if (any_l !== 1'b1) begin bad++; $display("FAIL lvl_any got=%b exp=1", any_l); end
    endtask

    task automatic test_async_rst;
        do_reset(8'h00);
        req_in = 8'hFF;
        tick(3);
        req_in = 8'hF0;
        tick(3);
        req_in = 8'hFF;
        tick(3);
        total++; if (pend !== 8'hFF) begin bad++; $display("FAIL arst_setup_pend got=%h exp=ff", pend); end
        total++; if (ovf !== 8'h0F) begin bad++; $display("FAIL arst_setup_ovf got=%h exp=0f", ovf); end
        #2 rst = 1'b1;
        #1;
        total++; if (pend !== 8'h00) begin bad++; $display("FAIL arst_pend got=%h exp=00", pend); end
        total++; if (ovf !== 8'h00) begin bad++; $display("FAIL arst_ovf got=%h exp=00", ovf); end
        total++; if (any !== 1'b0) begin bad++; $display("FAIL arst_any got=%b exp=0", any); end
        #1 rst = 1'b0;
        tick(2);
        total++; if (pend !== 8'h00) begin bad++; $display("FAIL release_early got=%h exp=00", pend); end
        tick(1);
        total++; if (pend !== 8'hFF) begin bad++; $display("FAIL release_edge got=%h exp=ff", pend); end
        // Event caught in s1 only, then reset: must vanish.
        do_reset(8'h00);
        req_in = 8'h02;
        tick(1);
        #2 rst = 1'b1;
        req_in = 8'h00;
        #1 rst = 1'b0;
        tick(4);
        total++; if (pend !== 8'h00) begin bad++; $display("FAIL inflight_discard got=%h exp=00", pend); end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_ack();
        test_ovf();
        test_enable();
        test_clr_all();
        test_multi_level();
        test_async_rst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
